// File: rtl/owm_pkg.sv
// Shared definitions for the OWM 1-wire master: command encodings,
// slot sequencer states and standard-speed timings in time-base ticks.
package owm_pkg;

  localparam logic [1:0] CMD_W0  = 2'b00;
  localparam logic [1:0] CMD_W1  = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;
  localparam logic [1:0] CMD_RST = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int unsigned STD_T_RST_LOW = 480;
  localparam int unsigned STD_T_RST_SMP = 550;
  localparam int unsigned STD_T_RST_END = 960;
  localparam int unsigned STD_T_W1_LOW  = 6;
  localparam int unsigned STD_T_W0_LOW  = 60;
  localparam int unsigned STD_T_RD_SMP  = 15;
  localparam int unsigned STD_T_SLOT    = 70;

endpackage

// File: rtl/owm_slot_counter.sv
// General-purpose up counter with synchronous clear (priority) and enable;
// out flags the all-ones terminal value.
module counter #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (ena) cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
  end

  assign out = &cnt;

endmodule

// File: rtl/owm_slot.sv
// 1-wire bit-slot sequencer: times reset/presence, write and read slots in
// time-base ticks, drives the open-drain pull-down and samples the bus.
module owm_slot import owm_pkg::*; #(
  parameter int          CW        = 10,
  parameter int unsigned T_RST_LOW = STD_T_RST_LOW,
  parameter int unsigned T_RST_SMP = STD_T_RST_SMP,
  parameter int unsigned T_RST_END = STD_T_RST_END,
  parameter int unsigned T_W1_LOW  = STD_T_W1_LOW,
  parameter int unsigned T_W0_LOW  = STD_T_W0_LOW,
  parameter int unsigned T_RD_SMP  = STD_T_RD_SMP,
  parameter int unsigned T_SLOT    = STD_T_SLOT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req,
  input  logic [1:0] cmd,
  output logic       rdy,
  input  logic       abort,
  output logic       done,
  output logic       rdat,
  output logic       pres,
  output logic       owr_oe,
  input  logic       owr_i
);

  if (!(T_W1_LOW >= 1 && T_W1_LOW < T_RD_SMP && T_RD_SMP < T_W0_LOW &&
        T_W0_LOW < T_SLOT && T_RST_LOW >= 1 && T_RST_LOW < T_RST_SMP &&
        T_RST_SMP < T_RST_END && T_SLOT < (1 << CW) && T_RST_END < (1 << CW)))
  begin : g_param_check
    $error("owm_slot: inconsistent slot timing parameters");
  end

  localparam logic [CW-1:0] ONE       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] K_RST_LOW = CW'(T_RST_LOW);
  localparam logic [CW-1:0] K_RST_SMP = CW'(T_RST_SMP);
  localparam logic [CW-1:0] K_RST_END = CW'(T_RST_END);
  localparam logic [CW-1:0] K_W1_LOW  = CW'(T_W1_LOW);
  localparam logic [CW-1:0] K_W0_LOW  = CW'(T_W0_LOW);
  localparam logic [CW-1:0] K_RD_SMP  = CW'(T_RD_SMP);
  localparam logic [CW-1:0] K_SLOT    = CW'(T_SLOT);

  state_t        state, state_nx;
  logic          owr_m, owr_s;
  logic [1:0]    cmd_q;
  logic [CW-1:0] t_low, t_smp, t_end, cnt;
  logic          accept, ev_low, ev_smp, ev_end;
  logic          unused_cnt_out;

  // Bus idles high, so the synchroniser resets to 1 to avoid a false low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owr_m <= 1'b1;
      owr_s <= 1'b1;
    end else begin
      owr_m <= owr_i;
      owr_s <= owr_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    ev_low   = 1'b0;
    ev_smp   = 1'b0;
    ev_end   = 1'b0;
    case (state)
      IDLE: begin
        if (req && !abort) begin
          accept   = 1'b1;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (tick) begin
          ev_low = (cnt == t_low - ONE);
          ev_smp = (cnt == t_smp - ONE);
          ev_end = (cnt == t_end - ONE);
          if (ev_end) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rdy = (state == IDLE);

  counter #(.CW(CW)) u_timer (
    .clk (clk),
    .rst (rst),
    .ena (tick && state == ACTIVE),
    .clr (accept || ev_end || abort),
    .cnt (cnt),
    .out (unused_cnt_out)
  );

  // Slot datapath: timing profile latched at accept, pull-down and samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q  <= CMD_W0;
      t_low  <= '0;
      t_smp  <= '0;
      t_end  <= '0;
      done   <= 1'b0;
      rdat   <= 1'b0;
      pres   <= 1'b0;
      owr_oe <= 1'b0;
    end else begin
      done <= ev_end;
      if (accept) begin
        cmd_q  <= cmd;
        owr_oe <= 1'b1;
        case (cmd)
          CMD_RST: begin t_low <= K_RST_LOW; t_smp <= K_RST_SMP; t_end <= K_RST_END; end
          CMD_W0:  begin t_low <= K_W0_LOW;  t_smp <= K_RD_SMP;  t_end <= K_SLOT;    end
          default: begin t_low <= K_W1_LOW;  t_smp <= K_RD_SMP;  t_end <= K_SLOT;    end
        endcase
      end else if (state == ACTIVE && abort) begin
        owr_oe <= 1'b0;
      end else if (ev_low) begin
        owr_oe <= 1'b0;
      end
      if (ev_smp) begin
        if (cmd_q == CMD_RST) pres <= ~owr_s;
        else                  rdat <= owr_s;
      end
    end
  end

endmodule

// File: tb/tb_owm_slot.sv
// Directed bench for owm_slot: slot timing, sampling, presence, abort,
// asynchronous reset and request filtering with a slower time base.
module tb_owm_slot;
  import owm_pkg::*;

  logic clk = 1'b0;
  logic rst, tick, req, abort, pull;
  logic [1:0] cmd;
  logic rdy, done, rdat, pres, owr_oe;
  wire  owr_i;

  // Open-drain bus: low when the master or the emulated slave pulls.
  assign owr_i = ~(owr_oe | pull);

  owm_slot dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .cmd(cmd), .rdy(rdy),
    .abort(abort), .done(done), .rdat(rdat), .pres(pres),
    .owr_oe(owr_oe), .owr_i(owr_i)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int per = 1, phase = 0, ticks_seen = 0;
  int m_first_oe, m_oe_cnt, m_done_edge, m_done_cnt, m_rdy_at_done;
  int m_ab_oe_before, m_ab_oe_after, m_ab_rdy_after;

  task automatic drive_tick();
    tick  = (phase == 0);
    phase = (phase + 1 >= per) ? 0 : phase + 1;
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and runs a fixed number of edges, recording what the
  // outputs did; the tick phase restarts so the accept edge carries a tick.
  task automatic applyStimulus(input logic [1:0] c, input int period, input int plo,
                               input int phi, input bit spam, input int abort_tick,
                               input int max_cyc);
    bit ticked;
    per = period; phase = 0; ticks_seen = 0;
    m_oe_cnt = 0; m_done_edge = -1; m_done_cnt = 0; m_rdy_at_done = -1;
    m_ab_oe_before = -1; m_ab_oe_after = -1; m_ab_rdy_after = -1;
    req = 1'b1; cmd = c;
    drive_tick();
    pull = (plo <= 0 && phi > 0);
    clk_step();
    req = 1'b0;
    m_first_oe = int'(owr_oe);
    if (owr_oe) m_oe_cnt++;
    for (int e = 1; e <= max_cyc; e++) begin
      drive_tick();
      ticked = tick;
      pull  = (ticks_seen >= plo && ticks_seen < phi);
      req   = spam && (e % 3 == 0) && ticks_seen < 60;
      cmd   = spam ? CMD_RST : c;
      abort = (abort_tick >= 0 && ticked && ticks_seen == abort_tick);
      if (abort) m_ab_oe_before = int'(owr_oe);
      clk_step();
      if (abort) begin
        m_ab_oe_after  = int'(owr_oe);
        m_ab_rdy_after = int'(rdy);
      end
      abort = 1'b0; req = 1'b0; cmd = c;
      if (ticked) ticks_seen++;
      if (owr_oe) m_oe_cnt++;
      if (done) begin
        m_done_cnt++;
        if (m_done_edge < 0) begin
          m_done_edge   = e;
          m_rdy_at_done = int'(rdy);
        end
      end
    end
    pull = 1'b0; tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; req = 1'b0; abort = 1'b0; cmd = CMD_W0; pull = 1'b0;
    repeat (3) clk_step();
    checks++; if (rdy !== 1'b1) begin failures++; $display("[TB] FAIL reset_rdy: observed %b required 1", rdy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: observed %b required 0", done); end
    checks++; if (rdat !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdat: observed %b required 0", rdat); end
    checks++; if (pres !== 1'b0) begin failures++; $display("[TB] FAIL reset_pres: observed %b required 0", pres); end
    checks++; if (owr_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_oe: observed %b required 0", owr_oe); end
    @(negedge clk); rst = 1'b0;
    clk_step();
  endtask

  task automatic test_write1();
    applyStimulus(CMD_W1, 1, 0, 0, 1'b0, -1, 75);
    checks++; if (m_first_oe !== 1) begin failures++; $display("[TB] FAIL w1_first_oe: observed %0d required 1", m_first_oe); end
    checks++; if (m_oe_cnt !== 6) begin failures++; $display("[TB] FAIL w1_oe_len: observed %0d required 6", m_oe_cnt); end
    checks++; if (m_done_edge !== 70) begin failures++; $display("[TB] FAIL w1_done_edge: observed %0d required 70", m_done_edge); end
    checks++; if (m_done_cnt !== 1) begin failures++; $display("[TB] FAIL w1_done_cnt: observed %0d required 1", m_done_cnt); end
    checks++; if (rdat !== 1'b1) begin failures++; $display("[TB] FAIL w1_rdat: observed %b required 1", rdat); end
  endtask

  task automatic test_write0();
    applyStimulus(CMD_W0, 1, 0, 0, 1'b0, -1, 75);
    checks++; if (m_oe_cnt !== 60) begin failures++; $display("[TB] FAIL w0_oe_len: observed %0d required 60", m_oe_cnt); end
    checks++; if (m_done_edge !== 70) begin failures++; $display("[TB] FAIL w0_done_edge: observed %0d required 70", m_done_edge); end
    checks++; if (m_rdy_at_done !== 1) begin failures++; $display("[TB] FAIL w0_rdy_at_done: observed %0d required 1", m_rdy_at_done); end
    checks++; if (rdat !== 1'b0) begin failures++; $display("[TB] FAIL w0_rdat: observed %b required 0", rdat); end
  endtask

  task automatic test_read();
    applyStimulus(CMD_RD, 1, 0, 30, 1'b0, -1, 75);
    checks++; if (m_oe_cnt !== 6) begin failures++; $display("[TB] FAIL rd0_oe_len: observed %0d required 6", m_oe_cnt); end
    checks++; if (m_done_edge !== 70) begin failures++; $display("[TB] FAIL rd0_done_edge: observed %0d required 70", m_done_edge); end
    checks++; if (rdat !== 1'b0) begin failures++; $display("[TB] FAIL rd0_rdat: observed %b required 0", rdat); end
    applyStimulus(CMD_RD, 1, 0, 0, 1'b0, -1, 75);
    checks++; if (m_done_cnt !== 1) begin failures++; $display("[TB] FAIL rd1_done_cnt: observed %0d required 1", m_done_cnt); end
    checks++; if (rdat !== 1'b1) begin failures++; $display("[TB] FAIL rd1_rdat: observed %b required 1", rdat); end
  endtask

  task automatic test_reset_cycle();
    applyStimulus(CMD_RST, 1, 500, 620, 1'b0, -1, 970);
    checks++; if (m_oe_cnt !== 480) begin failures++; $display("[TB] FAIL rst_oe_len: observed %0d required 480", m_oe_cnt); end
    checks++; if (m_done_edge !== 960) begin failures++; $display("[TB] FAIL rst_done_edge: observed %0d required 960", m_done_edge); end
    checks++; if (pres !== 1'b1) begin failures++; $display("[TB] FAIL rst_pres: observed %b required 1", pres); end
  endtask

  task automatic test_rst_midcycle();
    applyStimulus(CMD_RST, 1, 0, 0, 1'b0, -1, 100);
    checks++; if (owr_oe !== 1'b1) begin failures++; $display("[TB] FAIL mid_oe_before: observed %b required 1", owr_oe); end
    #2 rst = 1'b1;
    #1;
    checks++; if (owr_oe !== 1'b0) begin failures++; $display("[TB] FAIL mid_oe_async: observed %b required 0", owr_oe); end
    checks++; if (pres !== 1'b0) begin failures++; $display("[TB] FAIL mid_pres: observed %b required 0", pres); end
    @(negedge clk); rst = 1'b0;
    clk_step();
    checks++; if (rdy !== 1'b1) begin failures++; $display("[TB] FAIL mid_rdy_after: observed %b required 1", rdy); end
  endtask

  task automatic test_presence_absent();
    applyStimulus(CMD_RST, 1, 0, 0, 1'b0, -1, 970);
    checks++; if (m_done_edge !== 960) begin failures++; $display("[TB] FAIL nopres_done_edge: observed %0d required 960", m_done_edge); end
    checks++; if (pres !== 1'b0) begin failures++; $display("[TB] FAIL nopres_pres: observed %b required 0", pres); end
  endtask

  task automatic test_slow_tick();
    applyStimulus(CMD_W0, 4, 0, 0, 1'b1, -1, 290);
    checks++; if (m_oe_cnt !== 240) begin failures++; $display("[TB] FAIL slow_oe_len: observed %0d required 240", m_oe_cnt); end
    checks++; if (m_done_edge !== 280) begin failures++; $display("[TB] FAIL slow_done_edge: observed %0d required 280", m_done_edge); end
    checks++; if (m_done_cnt !== 1) begin failures++; $display("[TB] FAIL slow_done_cnt: observed %0d required 1", m_done_cnt); end
  endtask

  task automatic test_abort();
    applyStimulus(CMD_W0, 1, 0, 0, 1'b0, 20, 80);
    checks++; if (m_ab_oe_before !== 1) begin failures++; $display("[TB] FAIL abort_oe_before: observed %0d required 1", m_ab_oe_before); end
    checks++; if (m_ab_oe_after !== 0) begin failures++; $display("[TB] FAIL abort_oe_after: observed %0d required 0", m_ab_oe_after); end
    checks++; if (m_ab_rdy_after !== 1) begin failures++; $display("[TB] FAIL abort_rdy: observed %0d required 1", m_ab_rdy_after); end
    checks++; if (m_oe_cnt !== 21) begin failures++; $display("[TB] FAIL abort_oe_len: observed %0d required 21", m_oe_cnt); end
    checks++; if (m_done_cnt !== 0) begin failures++; $display("[TB] FAIL abort_done_cnt: observed %0d required 0", m_done_cnt); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(CMD_W1, 1, 0, 0, 1'b0, -1, 75);
    checks++; if (m_done_edge !== 70) begin failures++; $display("[TB] FAIL b2b_done_edge: observed %0d required 70", m_done_edge); end
    checks++; if (rdat !== 1'b1) begin failures++; $display("[TB] FAIL b2b_rdat: observed %b required 1", rdat); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write1();
    test_write0();
    test_read();
    test_reset_cycle();
    test_rst_midcycle();
    test_presence_absent();
    test_slow_tick();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
